button_event_gen: RTL and testbench

//  Consumes one debounced level (1 = pressed) and emits 1-cycle event pulses: press, release, click, double-click, long-press, auto-repeat.

---
 rtl/button_event_pkg.sv | 36 +++
 rtl/btn_edge_detect.sv | 22 ++
 rtl/button_event_gen.sv | 130 +++++++++++++
 tb/tb_button_event_gen.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared types and default timing for the button event generator.
// Timing defaults assume a 50 MHz system clock.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    HOLD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic dclick;
    logic lng;
    logic rpt;
  } ev_t;

  localparam int DEF_LONG_CYCLES   = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;
  localparam int DEF_DCLICK_CYCLES = 12_500_000;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registers a synchronous level and flags its rising
// and falling edges combinationally against the delayed copy.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  // delayed copy of the input level
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/button_event_gen.sv
// Turns one debounced key level into press/release/click/
// double-click/long-press/auto-repeat single-cycle pulses.
module button_event_gen
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_db,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dclick_o,
  output logic long_o,
  output logic repeat_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(
    max3(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST =
    CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DC_LAST =
    CNT_W'(DCLICK_CYCLES - 1);

  logic rise;
  logic fall;

  state_t state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  ev_t ev_q, ev_d;
  logic busy_q;

  btn_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (btn_db),
    .rise (rise),
    .fall (fall)
  );

  // next state, timer and event pulses; edges beat timeouts
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    ev_d    = '0;
    if (!en) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          timer_d = '0;
          if (rise) begin
            state_d  = PRESS;
            ev_d.press = 1'b1;
          end
        end
        PRESS: begin
          if (fall) begin
            state_d  = GAP;
            ev_d.rel = 1'b1;
          end else if (timer_q == LONG_LAST) begin
            state_d  = HOLD;
            ev_d.lng = 1'b1;
          end
        end
        HOLD: begin
          if (fall) begin
            state_d  = IDLE;
            ev_d.rel = 1'b1;
          end else if (timer_q == REP_LAST) begin
            timer_d  = '0;
            ev_d.rpt = 1'b1;
          end
        end
        GAP: begin
          if (rise) begin
            state_d     = PRESS2;
            ev_d.press  = 1'b1;
            ev_d.dclick = 1'b1;
          end else if (timer_q == DC_LAST) begin
            state_d    = IDLE;
            ev_d.click = 1'b1;
          end
        end
        PRESS2: begin
          timer_d = '0;
          if (fall) begin
            state_d  = IDLE;
            ev_d.rel = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_d != state_q) timer_d = '0;
    end
  end

  // state, timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      ev_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ev_q    <= ev_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign press_o   = ev_q.press;
  assign release_o = ev_q.rel;
  assign click_o   = ev_q.click;
  assign dclick_o  = ev_q.dclick;
  assign long_o    = ev_q.lng;
  assign repeat_o  = ev_q.rpt;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with short timings
// (LONG=10, REPEAT=4, DCLICK=6).
module tb_button_event_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic btn_db = 1'b0;
  logic press_o, release_o, click_o, dclick_o;
  logic long_o, repeat_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc;
  int n_press, n_rel, n_click, n_dclick, n_long, n_rep;
  int t_press, t_rel, t_click, t_dclick, t_long, t_rep;
  int t_bfall;
  logic busy_prev;

  button_event_gen #(
    .LONG_CYCLES   (10),
    .REPEAT_CYCLES (4),
    .DCLICK_CYCLES (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .btn_db    (btn_db),
    .press_o   (press_o),
    .release_o (release_o),
    .click_o   (click_o),
    .dclick_o  (dclick_o),
    .long_o    (long_o),
    .repeat_o  (repeat_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic clr();
    cyc = 0;
    n_press = 0; n_rel = 0; n_click = 0;
    n_dclick = 0; n_long = 0; n_rep = 0;
    t_press = -1; t_rel = -1; t_click = -1;
    t_dclick = -1; t_long = -1; t_rep = -1;
    t_bfall = -1;
    busy_prev = busy_o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (press_o)   begin n_press++;  t_press = cyc;  end
    if (release_o) begin n_rel++;    t_rel = cyc;    end
    if (click_o)   begin n_click++;  t_click = cyc;  end
    if (dclick_o)  begin n_dclick++; t_dclick = cyc; end
    if (long_o)    begin n_long++;   t_long = cyc;   end
    if (repeat_o)  begin n_rep++;    t_rep = cyc;    end
    if (busy_prev && !busy_o) t_bfall = cyc;
    busy_prev = busy_o;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [6:0] o;
    rst = 1'b1; en = 1'b1; btn_db = 1'b0;
    ticks(3);
    o = {press_o, release_o, click_o, dclick_o,
         long_o, repeat_o, busy_o};
    checks++;
    if (o !== 7'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 0", o);
    end
    rst = 1'b0;
    clr();
    ticks(3);
    checks++;
    if (busy_o !== 1'b0 || n_press !== 0) begin
      errors++;
      $display("FAIL reset_idle: busy %b press %0d want 0 0",
               busy_o, n_press);
    end
  endtask

  task automatic test_click();
    clr();
    btn_db = 1'b1; ticks(3);
    btn_db = 1'b0; ticks(10);
    checks++;
    if (t_press !== 1 || n_press !== 1) begin
      errors++;
      $display("FAIL click_press: at %0d n %0d want 1 1",
               t_press, n_press);
    end
    checks++;
    if (t_rel !== 4 || n_rel !== 1) begin
      errors++;
      $display("FAIL click_release: at %0d n %0d want 4 1",
               t_rel, n_rel);
    end
    checks++;
    if (t_click !== 10 || n_click !== 1) begin
      errors++;
      $display("FAIL click_pulse: at %0d n %0d want 10 1",
               t_click, n_click);
    end
    checks++;
    if (t_bfall !== 10) begin
      errors++;
      $display("FAIL click_busy_fall: at %0d want 10", t_bfall);
    end
  endtask

  task automatic test_dclick();
    clr();
    btn_db = 1'b1; ticks(3);
    btn_db = 1'b0; ticks(2);
    btn_db = 1'b1; ticks(3);
    btn_db = 1'b0; ticks(10);
    checks++;
    if (n_press !== 2 || t_press !== 6) begin
      errors++;
      $display("FAIL dclick_press: n %0d last %0d want 2 6",
               n_press, t_press);
    end
    checks++;
    if (n_dclick !== 1 || t_dclick !== 6) begin
      errors++;
      $display("FAIL dclick_pulse: n %0d at %0d want 1 6",
               n_dclick, t_dclick);
    end
    checks++;
    if (n_rel !== 2 || t_rel !== 9) begin
      errors++;
      $display("FAIL dclick_release: n %0d last %0d want 2 9",
               n_rel, t_rel);
    end
    checks++;
    if (n_click !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL dclick_noclick: clicks %0d busy %b want 0 0",
               n_click, busy_o);
    end
  endtask

  task automatic test_long_repeat();
    clr();
    btn_db = 1'b1; ticks(31);
    btn_db = 1'b0; ticks(12);
    checks++;
    if (n_long !== 1 || t_long !== 11) begin
      errors++;
      $display("FAIL long_pulse: n %0d at %0d want 1 11",
               n_long, t_long);
    end
    checks++;
    if (n_rep !== 5 || t_rep !== 31) begin
      errors++;
      $display("FAIL repeat_pulses: n %0d last %0d want 5 31",
               n_rep, t_rep);
    end
    checks++;
    if (n_rel !== 1 || t_rel !== 32) begin
      errors++;
      $display("FAIL long_release: n %0d at %0d want 1 32",
               n_rel, t_rel);
    end
    checks++;
    if (n_click !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL long_noclick: clicks %0d busy %b want 0 0",
               n_click, busy_o);
    end
  endtask

  task automatic test_races();
    clr();
    btn_db = 1'b1; ticks(10);
    btn_db = 1'b0; ticks(8);
    checks++;
    if (n_long !== 0 || t_rel !== 11) begin
      errors++;
      $display("FAIL race_fall_long: longs %0d rel %0d want 0 11",
               n_long, t_rel);
    end
    checks++;
    if (n_click !== 1 || t_click !== 17) begin
      errors++;
      $display("FAIL race_click_after: n %0d at %0d want 1 17",
               n_click, t_click);
    end
    clr();
    btn_db = 1'b1; ticks(2);
    btn_db = 1'b0; ticks(6);
    btn_db = 1'b1; ticks(2);
    btn_db = 1'b0; ticks(10);
    checks++;
    if (n_dclick !== 1 || t_dclick !== 9) begin
      errors++;
      $display("FAIL race_rise_gap: n %0d at %0d want 1 9",
               n_dclick, t_dclick);
    end
    checks++;
    if (n_click !== 0) begin
      errors++;
      $display("FAIL race_noclick: clicks %0d want 0", n_click);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] o;
    clr();
    btn_db = 1'b1; ticks(12);
    rst = 1'b1; tick();
    o = {press_o, release_o, click_o, dclick_o,
         long_o, repeat_o, busy_o};
    checks++;
    if (o !== 7'b0 || n_long !== 1) begin
      errors++;
      $display("FAIL rst_hold: outs %b longs %0d want 0 1",
               o, n_long);
    end
    ticks(2);
    clr();
    rst = 1'b0;
    ticks(4);
    checks++;
    if (n_press !== 1 || t_press !== 1) begin
      errors++;
      $display("FAIL rst_held_press: n %0d at %0d want 1 1",
               n_press, t_press);
    end
    btn_db = 1'b0; ticks(3);
    rst = 1'b1; tick();
    o = {press_o, release_o, click_o, dclick_o,
         long_o, repeat_o, busy_o};
    checks++;
    if (o !== 7'b0) begin
      errors++;
      $display("FAIL rst_gap: outs %b want 0", o);
    end
    rst = 1'b0;
    clr();
    ticks(10);
    checks++;
    if (n_click !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_gap_noclick: clicks %0d busy %b want 0 0",
               n_click, busy_o);
    end
  endtask

  task automatic test_enable();
    int tot;
    clr();
    btn_db = 1'b1; ticks(3);
    clr();
    en = 1'b0; ticks(5);
    tot = n_press + n_rel + n_click + n_dclick + n_long + n_rep;
    checks++;
    if (tot !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL en_off: pulses %0d busy %b want 0 0",
               tot, busy_o);
    end
    en = 1'b1; ticks(12);
    checks++;
    if (n_press !== 0 || n_long !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL en_rehold: press %0d long %0d busy %b want 0",
               n_press, n_long, busy_o);
    end
    btn_db = 1'b0; ticks(2);
    btn_db = 1'b1; tick();
    checks++;
    if (press_o !== 1'b1 || n_rel !== 0) begin
      errors++;
      $display("FAIL en_fresh_press: press %b rel %0d want 1 0",
               press_o, n_rel);
    end
    btn_db = 1'b0; ticks(10);
  endtask

  initial begin
    test_reset();
    test_click();
    test_dclick();
    test_long_repeat();
    test_races();
    test_reset_mid();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
